// File: rtl/fetch_pkg.sv
// Shared fetch-front-end types: opcode/RVC constants, FSM states, queue entry layout.
// Build option FETCH_RVC_EN (see fetch_predecode) does not change these definitions.
package fetch_pkg;

    // Queue entries carry PCs at the widest supported XLEN; narrower builds zero-extend.
    localparam int PC_MAX_W = 64;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] RVC_Q1  = 2'b01;
    localparam logic [1:0] RVC_Q2  = 2'b10;
    localparam logic [2:0] F3_CJAL = 3'b001;
    localparam logic [2:0] F3_CJ   = 3'b101;
    localparam logic [2:0] F3_CJR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]         inst;
        logic [PC_MAX_W-1:0] pc;
        logic [PC_MAX_W-1:0] pred_pc;
        logic                is_rvc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Static next-PC predecode of one fetched word; FETCH_RVC_EN enables 16-bit handling.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle on the current response.
module fetch_predecode
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            is_rvc,
    output logic            halt
);

    logic [XLEN-1:0] imm_j;
    assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

`ifdef FETCH_RVC_EN
    logic [XLEN-1:0] imm_cj;
    assign imm_cj = {{(XLEN-11){inst[12]}}, inst[8], inst[10:9], inst[6], inst[7],
                     inst[2], inst[11], inst[5:3], 1'b0};
`else
    logic unused_rd;
    assign unused_rd = ^inst[11:7];
`endif

    always_comb begin
        next_pc = pc + XLEN'(4);
        is_rvc  = 1'b0;
        halt    = 1'b0;
`ifdef FETCH_RVC_EN
        if (inst[1:0] != 2'b11) begin
            is_rvc  = 1'b1;
            next_pc = pc + XLEN'(2);
            if (inst[1:0] == RVC_Q1 && (inst[15:13] == F3_CJ || inst[15:13] == F3_CJAL))
                next_pc = pc + imm_cj;
            else if (inst[1:0] == RVC_Q2 && inst[15:13] == F3_CJR &&
                     inst[6:2] == 5'd0 && inst[11:7] != 5'd0)
                halt = 1'b1;
        end else
`endif
        begin
            case (inst[6:0])
                OPC_JAL:    next_pc = pc + imm_j;
                OPC_JALR:   halt    = 1'b1;
                OPC_BRANCH: next_pc = pc + XLEN'(4);   // static not-taken
                default:    next_pc = pc + XLEN'(4);
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, QDEPTH-entry decoupling queue (FETCH_RVC_EN selects RVC support).
// Latency: response sampled at edge k appears on deq_* after edge k; issue-to-issue at least 2 cycles.
// Backpressure: deq_ready stalls dequeue; no request is issued while the queue is full.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_valid,
    input  logic [31:0]     mem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [31:0]     deq_inst,
    output logic [XLEN-1:0] deq_pc,
    output logic [XLEN-1:0] deq_pred_pc,
    output logic            deq_is_rvc,
    output logic            flush
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic            drop;
    logic [AW-1:0]   head, tail, head_n;
    logic [CW-1:0]   count, remain;
    fetch_entry_t    q [QDEPTH];
    fetch_entry_t    deq_q, enq_entry;
    logic [XLEN-1:0] pd_next, redirect_tgt;
    logic            pd_rvc, pd_halt, enq, fire;

    fetch_predecode #(.XLEN(XLEN)) u_predecode (
        .inst    (mem_data),
        .pc      (fetch_pc),
        .next_pc (pd_next),
        .is_rvc  (pd_rvc),
        .halt    (pd_halt)
    );

`ifdef FETCH_RVC_EN
    assign redirect_tgt = {redirect_pc[XLEN-1:1], 1'b0};
`else
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    generate
        if (XLEN < PC_MAX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^{deq_q.pc[PC_MAX_W-1:XLEN], deq_q.pred_pc[PC_MAX_W-1:XLEN]};
        end
    endgenerate

    assign deq_valid   = (count != '0);
    assign fire        = deq_valid & deq_ready;
    assign enq         = (state == WAIT) && mem_valid && !redirect_valid;
    assign head_n      = head + AW'(fire);
    assign remain      = count - CW'(fire);
    assign deq_inst    = deq_q.inst;
    assign deq_pc      = deq_q.pc[XLEN-1:0];
    assign deq_pred_pc = deq_q.pred_pc[XLEN-1:0];
    assign deq_is_rvc  = deq_q.is_rvc;

    always_comb begin
        enq_entry.inst    = pd_rvc ? {16'h0000, mem_data[15:0]} : mem_data;
        enq_entry.pc      = PC_MAX_W'(fetch_pc);
        enq_entry.pred_pc = PC_MAX_W'(pd_next);
        enq_entry.is_rvc  = pd_rvc;
    end

    always_ff @(posedge clk) begin
        if (enq)
            q[tail] <= enq_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            flush    <= 1'b0;
            deq_q    <= '0;
        end else begin
            mem_req <= 1'b0;
            flush   <= 1'b0;
            if (redirect_valid) begin
                // A response arriving with the redirect is simply lost; otherwise one is still owed.
                state    <= IDLE;
                fetch_pc <= redirect_tgt;
                drop     <= ((state == WAIT) || drop) && !mem_valid;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                flush    <= 1'b1;
            end else begin
                head  <= head_n;
                count <= count + CW'(enq) - CW'(fire);
                if (enq)
                    tail <= tail + AW'(1);
                // Keep the registered head view in step with the post-edge queue head.
                if (enq && remain == '0)
                    deq_q <= enq_entry;
                else if (remain != '0)
                    deq_q <= q[head_n];
                case (state)
                    IDLE: begin
                        if (drop) begin
                            if (mem_valid)
                                drop <= 1'b0;
                        end else if (count < CW'(QDEPTH)) begin
                            mem_req  <= 1'b1;
                            mem_addr <= fetch_pc;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_valid) begin
                            fetch_pc <= pd_next;
                            state    <= pd_halt ? HALT : IDLE;
                        end
                    end
                    HALT:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/redirect/backpressure scenarios with a behavioural memory.
module tb_fetch_unit;

    localparam int XLEN   = 32;
    localparam int QDEPTH = 4;
    localparam logic [31:0] JALR  = 32'h000080E7;
    localparam logic [31:0] JAL20 = 32'h0200006F;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req, mem_valid;
    logic [XLEN-1:0] mem_addr;
    logic [31:0]     mem_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_valid, deq_ready, deq_is_rvc, flush;
    logic [31:0]     deq_inst;
    logic [XLEN-1:0] deq_pc, deq_pred_pc;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_inst       (deq_inst),
        .deq_pc         (deq_pc),
        .deq_pred_pc    (deq_pred_pc),
        .deq_is_rvc     (deq_is_rvc),
        .flush          (flush)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        rvc;
    } ent_t;

    ent_t        exp_ent [$];
    logic [31:0] exp_addr [$];
    logic [31:0] imem [logic [31:0]];
    int n_cmp = 0, n_err = 0, req_cnt = 0, lat = 1, pending = 0;
    logic [31:0] req_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return 32'h00000013;
    endfunction

    task automatic push(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] pred, input logic rvc);
        ent_t e;
        e.inst = inst; e.pc = pc; e.pred = pred; e.rvc = rvc;
        exp_ent.push_back(e);
        exp_addr.push_back(pc);
    endtask

    // Memory model: single outstanding request, response lat cycles after the request cycle.
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (rst_n && mem_req)
                chk("req_while_outstanding", 32'(pending), 32'd0);
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = rd(req_addr);
                end
            end
            if (rst_n && mem_req) begin
                pending  = lat;
                req_addr = mem_addr;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a request or dequeues an entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                req_cnt++;
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_req: got addr %h expected none", mem_addr);
                end else
                    chk("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (rst_n && deq_valid && deq_ready) begin
                if (exp_ent.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_deq: got pc %h expected none", deq_pc);
                end else begin
                    ent_t e;
                    e = exp_ent.pop_front();
                    chk("deq_inst", deq_inst, e.inst);
                    chk("deq_pc", deq_pc, e.pc);
                    chk("deq_pred_pc", deq_pred_pc, e.pred);
                    chk("deq_is_rvc", 32'(deq_is_rvc), 32'(e.rvc));
                end
            end
        end
    end

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_addr.size() == 0 && exp_ent.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_pending", 32'(exp_addr.size() + exp_ent.size()), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("flush_pulse", 32'(flush), 32'd1);
        chk("flush_empty", 32'(deq_valid), 32'd0);
        @(posedge clk); #1;
        chk("flush_clear", 32'(flush), 32'd0);
    endtask

    task automatic halt_window(input string name, input int cycles);
        int n0;
        n0 = req_cnt;
        repeat (cycles) @(posedge clk);
        #1;
        chk(name, 32'(req_cnt - n0), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit found;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;

        repeat (3) @(posedge clk); #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_deq_inst", deq_inst, 32'd0);
        chk("rst_deq_pc", deq_pc, 32'd0);
        chk("rst_deq_pred_pc", deq_pred_pc, 32'd0);
        chk("rst_deq_is_rvc", 32'(deq_is_rvc), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);

        // Sequential addi stream ending in JALR.
        imem[32'h10C] = JALR;
        push(32'h13, 32'h100, 32'h104, 1'b0);
        push(32'h13, 32'h104, 32'h108, 1'b0);
        push(32'h13, 32'h108, 32'h10C, 1'b0);
        push(JALR,   32'h10C, 32'h110, 1'b0);
        deq_ready = 1'b1;
        rst_n     = 1'b1;
        wait_drain(200);
        halt_window("halt_10c_no_req", 10);

        // JAL +0x20.
        imem[32'h100] = JAL20;
        imem[32'h120] = JALR;
        push(JAL20, 32'h100, 32'h120, 1'b0);
        push(JALR,  32'h120, 32'h124, 1'b0);
        do_redirect(32'h100);
        wait_drain(200);

        // JALR at 0x200, then redirect with bit 0 set.
        imem[32'h200] = JALR;
        push(JALR, 32'h200, 32'h204, 1'b0);
        do_redirect(32'h200);
        wait_drain(200);
        halt_window("halt_200_no_req", 10);
        imem[32'h340] = JALR;
        push(JALR, 32'h340, 32'h344, 1'b0);
        do_redirect(32'h341);
        wait_drain(200);

        // Full queue under backpressure, then a single dequeue.
        deq_ready = 1'b0;
        exp_addr.push_back(32'h400);
        exp_addr.push_back(32'h404);
        exp_addr.push_back(32'h408);
        exp_addr.push_back(32'h40C);
        n0 = req_cnt;
        do_redirect(32'h400);
        repeat (30) @(posedge clk); #1;
        chk("full_req_count", 32'(req_cnt - n0), 32'd4);
        chk("full_deq_valid", 32'(deq_valid), 32'd1);
        chk("full_head_pc", deq_pc, 32'h400);
        exp_ent.push_back('{inst: 32'h13, pc: 32'h400, pred: 32'h404, rvc: 1'b0});
        exp_addr.push_back(32'h410);
        n0 = req_cnt;
        @(posedge clk); #1;
        deq_ready = 1'b1;
        @(posedge clk); #1;
        deq_ready = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("one_more_req", 32'(req_cnt - n0), 32'd1);
        chk("new_head_pc", deq_pc, 32'h404);
        wait_drain(1);

        // Redirect while 0x108 is outstanding: stale response must be dropped.
        lat = 4;
        imem.delete(32'h100);
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h108);
        do_redirect(32'h100);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 32'h108) begin
                found = 1'b1;
                break;
            end
        end
        chk("saw_req_108", 32'(found), 32'd1);
        imem[32'h500] = JALR;
        push(JALR, 32'h500, 32'h504, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("drop_flush", 32'(flush), 32'd1);
        chk("drop_empty", 32'(deq_valid), 32'd0);
        deq_ready = 1'b1;
        wait_drain(200);

`ifdef FETCH_RVC_EN
        // C.NOP, C.J +8, then C.JR halts.
        lat = 1;
        imem[32'h100] = 32'hA0210001;
        imem[32'h102] = 32'h0000A021;
        imem[32'h10A] = 32'h00008082;
        push(32'h00000001, 32'h100, 32'h102, 1'b1);
        push(32'h0000A021, 32'h102, 32'h10A, 1'b1);
        push(32'h00008082, 32'h10A, 32'h10C, 1'b1);
        do_redirect(32'h100);
        wait_drain(200);
        halt_window("halt_cjr_no_req", 10);
`endif

        repeat (5) @(posedge clk); #1;
        chk("final_empty", 32'(deq_valid), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
